hazard_flush_ctrl: RTL and testbench
====================================

Name: hazard_flush_ctrl

Overview:
Pipeline hazard and flush controller, the producer side of the ID/EX flush interface. It reads back the fields latched in ID/EX (MemRead, destination register) and the branch/jump outcome resolved in EX. It drives ID_Flush into the ID/EX register, plus the IF/ID flush, IF/ID hold and PC hold/redirect controls. It sequences multi-cycle load-use stalls and redirect bubbles, and keeps saturating stall/flush event counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (legal 1..15)
REDIRECT_BUBBLES, 1, cycles ID_Flush/IF_Flush stay high per taken branch/jump, including the detect cycle (legal 1..15)
CNT_W, 32, width of the event counters

Ports:
clk  in  1  pipeline clock; all state updates on negedge, the same edge as ID/EX
rst_n  in  1  asynchronous active-low reset
if_id_rs1_i  in  5  rs1 field of the instruction in ID
if_id_rs2_i  in  5  rs2 field of the instruction in ID
id_uses_rs1_i  in  1  ID instruction reads rs1
id_uses_rs2_i  in  1  ID instruction reads rs2
id_ex_MemRead_i  in  1  MemRead as latched in ID/EX
id_ex_wr_i  in  5  destination register as latched in ID/EX
ex_branch_taken_i  in  1  EX resolved a taken branch
ex_jump_i  in  2  Jump as latched in ID/EX (nonzero = JAL/JALR)
cnt_clr_i  in  1  synchronous clear of both counters
ID_Flush  out  1  bubble ID/EX on the next negedge
IF_Flush  out  1  zero IF/ID on the next negedge
IF_ID_Write  out  1  IF/ID load enable (0 = hold)
PCWrite  out  1  PC load enable (0 = hold)
pc_sel  out  1  1 = PC loads the EX redirect target
stall_count  out  CNT_W  load-use bubble cycles inserted, saturating
flush_count  out  CNT_W  redirect events accepted, saturating

Behaviour:
- Combinational terms:
  - load_use = id_ex_MemRead_i & (id_ex_wr_i != 0) & ((id_uses_rs1_i & if_id_rs1_i == id_ex_wr_i) | (id_uses_rs2_i & if_id_rs2_i == id_ex_wr_i)).
  - redirect = ex_branch_taken_i | (ex_jump_i != 0).
- States: RUN, STALL, REDIR. A 4-bit down-counter `rem` holds the remaining cycles.
- Outputs are Mealy in RUN and Moore in STALL/REDIR.
- RUN:
  - Idle: ID_Flush=0, IF_Flush=0, IF_ID_Write=1, PCWrite=1, pc_sel=0.
  - redirect (priority over load_use): ID_Flush=1, IF_Flush=1, PCWrite=1, pc_sel=1, IF_ID_Write=1. flush_count+1. If REDIRECT_BUBBLES>1: go to REDIR with rem=REDIRECT_BUBBLES-2; else stay in RUN.
  - load_use without redirect: ID_Flush=1, IF_Flush=0, PCWrite=0, IF_ID_Write=0, pc_sel=0. stall_count+1. If LOAD_STALL_CYCLES>1: go to STALL with rem=LOAD_STALL_CYCLES-2.
- STALL: same outputs as the load_use case; stall_count+1 each cycle. If rem==0, go to RUN, else rem-1.
  - A redirect during STALL overrides: outputs and transitions are exactly as for RUN+redirect, stall_count is not incremented, and the stall is abandoned.
- REDIR: ID_Flush=1, IF_Flush=1, PCWrite=1, pc_sel=0, IF_ID_Write=1. redirect and load_use are ignored (they come from squashed instructions). If rem==0, go to RUN, else rem-1.
- Counters: cnt_clr_i has priority over increment. Each counter holds at all-ones once saturated. At most +1 per counter per cycle.
- Reset (rst_n=0, asynchronous):
  - State=RUN, rem=0, counters=0.
  - Outputs are forced while rst_n is low: ID_Flush=1, IF_Flush=1, PCWrite=0, IF_ID_Write=0, pc_sel=0.
  - Reset asserted mid-STALL or mid-REDIR aborts the sequence. First normal RUN outputs appear after rst_n rises.
- x0 never hazards. Both rs1 and rs2 matching counts as one hazard.

Test Plan:
- Reset: rst_n=0 mid-REDIR -> ID_Flush=1, IF_Flush=1, PCWrite=0, IF_ID_Write=0, counters=0. Release -> RUN idle outputs (ID_Flush=0, IF_Flush=0, IF_ID_Write=1, PCWrite=1, pc_sel=0).
- Load-use, defaults: MemRead=1, wr=5, rs2=5, uses_rs2=1 -> exactly 1 cycle of ID_Flush=1, PCWrite=0, IF_ID_Write=0; stall_count=1. Same with wr=0 -> no stall.
- LOAD_STALL_CYCLES=3, hazard held -> 3 consecutive bubble cycles, then RUN; stall_count=3.
- REDIRECT_BUBBLES=3, ex_jump_i=2'b01 one cycle -> pc_sel=1 for 1 cycle; ID_Flush/IF_Flush=1 for 3 cycles; flush_count=1. A load_use raised in cycle 2 is ignored.
- LOAD_STALL_CYCLES=3 with branch_taken in the 2nd stall cycle -> redirect outputs that cycle, stall abandoned; stall_count=1, flush_count=1.
- CNT_W=4, 20 load-use events -> stall_count saturates at 15. cnt_clr_i together with an event -> counter reads 0.

Source files
------------

// File: rtl/hazard_flush_ctrl_if.sv
// rtl/hazard_flush_ctrl_if.sv - ID/EX hazard fields in, flush/hold/redirect controls out
interface hazard_flush_ctrl_if;
  logic [4:0] if_id_rs1_i;
  logic [4:0] if_id_rs2_i;
  logic       id_uses_rs1_i;
  logic       id_uses_rs2_i;
  logic       id_ex_MemRead_i;
  logic [4:0] id_ex_wr_i;
  logic       ex_branch_taken_i;
  logic [1:0] ex_jump_i;
  logic       ID_Flush;
  logic       IF_Flush;
  logic       IF_ID_Write;
  logic       PCWrite;
  logic       pc_sel;

  // controller side
  modport master (
    input  if_id_rs1_i, if_id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
    input  id_ex_MemRead_i, id_ex_wr_i, ex_branch_taken_i, ex_jump_i,
    output ID_Flush, IF_Flush, IF_ID_Write, PCWrite, pc_sel
  );

  // pipeline side
  modport slave (
    output if_id_rs1_i, if_id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
    output id_ex_MemRead_i, id_ex_wr_i, ex_branch_taken_i, ex_jump_i,
    input  ID_Flush, IF_Flush, IF_ID_Write, PCWrite, pc_sel
  );
endinterface

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - load-use stall and branch/jump flush sequencer with event counters
module hazard_flush_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REDIRECT_BUBBLES  = 1,
  parameter int CNT_W             = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hazard_flush_ctrl_if.master  bus,
  input  logic                 cnt_clr_i,
  output logic [CNT_W-1:0]     stall_count,
  output logic [CNT_W-1:0]     flush_count
);

  typedef enum logic [1:0] {RUN, STALL, REDIR} state_t;

  // Remaining-cycle loads; the detect cycle and the final cycle are both counted.
  localparam logic [3:0] STALL_REM = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
  localparam logic [3:0] REDIR_REM = (REDIRECT_BUBBLES > 1)  ? 4'(REDIRECT_BUBBLES - 2)  : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] rem_q, rem_d;
  logic       load_use, redirect;
  logic       stall_inc, flush_inc;
  logic       id_flush, if_flush, if_id_write, pc_write, pc_sel_c;

  assign load_use = bus.id_ex_MemRead_i & (bus.id_ex_wr_i != 5'd0) &
                    ((bus.id_uses_rs1_i & (bus.if_id_rs1_i == bus.id_ex_wr_i)) |
                     (bus.id_uses_rs2_i & (bus.if_id_rs2_i == bus.id_ex_wr_i)));
  assign redirect = bus.ex_branch_taken_i | (bus.ex_jump_i != 2'b00);

  // State and remaining-cycle register, on the same edge as ID/EX.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and pipeline controls; a redirect always wins over a stall.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    id_flush    = 1'b0;
    if_flush    = 1'b0;
    if_id_write = 1'b1;
    pc_write    = 1'b1;
    pc_sel_c    = 1'b0;
    case (state_q)
      RUN, STALL: begin
        if (redirect) begin
          id_flush  = 1'b1;
          if_flush  = 1'b1;
          pc_sel_c  = 1'b1;
          flush_inc = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_d = REDIR;
            rem_d   = REDIR_REM;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == STALL || load_use) begin
          id_flush    = 1'b1;
          if_id_write = 1'b0;
          pc_write    = 1'b0;
          stall_inc   = 1'b1;
          if (state_q == RUN) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              rem_d   = STALL_REM;
            end
          end else if (rem_q == 4'd0) begin
            state_d = RUN;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end
      end
      REDIR: begin
        id_flush = 1'b1;
        if_flush = 1'b1;
        if (rem_q == 4'd0) state_d = RUN;
        else               rem_d   = rem_q - 4'd1;
      end
      default: state_d = RUN;
    endcase
  end

  // While reset is held the pipeline is frozen and the ID/EX and IF/ID registers are bubbled.
  assign bus.ID_Flush    = ~rst_n | id_flush;
  assign bus.IF_Flush    = ~rst_n | if_flush;
  assign bus.IF_ID_Write = rst_n & if_id_write;
  assign bus.PCWrite     = rst_n & pc_write;
  assign bus.pc_sel      = rst_n & pc_sel_c;

  // Saturating event counters; clear beats increment.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else if (cnt_clr_i) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && stall_count != {CNT_W{1'b1}}) stall_count <= stall_count + 1'b1;
      if (flush_inc && flush_count != {CNT_W{1'b1}}) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// tb/tb_hazard_flush_ctrl.sv - directed checks for hazard_flush_ctrl
module tb_hazard_flush_ctrl;
  localparam logic [4:0] C_IDLE  = 5'b00110;
  localparam logic [4:0] C_STALL = 5'b10000;
  localparam logic [4:0] C_RDET  = 5'b11111;
  localparam logic [4:0] C_RHOLD = 5'b11110;
  localparam logic [4:0] C_RST   = 5'b11000;

  logic       clk;
  logic       rst_n;
  logic       cnt_clr_a, cnt_clr_b;
  logic [31:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;
  logic [4:0]  ctl_a, ctl_b;
  int          errors = 0;
  int          checks = 0;

  hazard_flush_ctrl_if bus_a ();
  hazard_flush_ctrl_if bus_b ();

  hazard_flush_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .cnt_clr_i(cnt_clr_a),
    .stall_count(stall_a), .flush_count(flush_a)
  );

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .REDIRECT_BUBBLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .cnt_clr_i(cnt_clr_b),
    .stall_count(stall_b), .flush_count(flush_b)
  );

  assign ctl_a = {bus_a.ID_Flush, bus_a.IF_Flush, bus_a.IF_ID_Write, bus_a.PCWrite, bus_a.pc_sel};
  assign ctl_b = {bus_b.ID_Flush, bus_b.IF_Flush, bus_b.IF_ID_Write, bus_b.PCWrite, bus_b.pc_sel};

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change one step after the posedge; state commits on the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic mr, input logic [4:0] wr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic [1:0] jmp);
    bus_a.id_ex_MemRead_i = mr;  bus_a.id_ex_wr_i = wr;
    bus_a.if_id_rs1_i = rs1;     bus_a.if_id_rs2_i = rs2;
    bus_a.id_uses_rs1_i = u1;    bus_a.id_uses_rs2_i = u2;
    bus_a.ex_branch_taken_i = br; bus_a.ex_jump_i = jmp;
  endtask

  task automatic drive_b(input logic mr, input logic [4:0] wr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic u1, input logic u2,
                         input logic br, input logic [1:0] jmp);
    bus_b.id_ex_MemRead_i = mr;  bus_b.id_ex_wr_i = wr;
    bus_b.if_id_rs1_i = rs1;     bus_b.if_id_rs2_i = rs2;
    bus_b.id_uses_rs1_i = u1;    bus_b.id_uses_rs2_i = u2;
    bus_b.ex_branch_taken_i = br; bus_b.ex_jump_i = jmp;
  endtask

  initial begin
    rst_n = 1'b0;
    cnt_clr_a = 1'b0;
    cnt_clr_b = 1'b0;
    drive_a(0, 0, 0, 0, 0, 0, 0, 2'b00);
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);

    // reset state
    next_cycle();
    check_eq("a_reset_ctl", 32'(ctl_a), 32'(C_RST));
    check_eq("a_reset_stall", stall_a, 32'd0);
    check_eq("a_reset_flush", flush_a, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("a_release_idle", 32'(ctl_a), 32'(C_IDLE));
    check_eq("b_release_idle", 32'(ctl_b), 32'(C_IDLE));

    // defaults: single-cycle load-use stall on rs2
    next_cycle();
    drive_a(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 2'b00);
    #1 check_eq("a_lu_stall", 32'(ctl_a), 32'(C_STALL));
    next_cycle();
    drive_a(0, 5'd5, 5'd0, 5'd5, 0, 1, 0, 2'b00);
    #1 check_eq("a_lu_after", 32'(ctl_a), 32'(C_IDLE));
    check_eq("a_lu_count", stall_a, 32'd1);

    // x0 destination never hazards
    drive_a(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 2'b00);
    #1 check_eq("a_x0_nostall", 32'(ctl_a), 32'(C_IDLE));
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("a_x0_count", stall_a, 32'd1);

    // rs1 and rs2 both matching is one hazard
    next_cycle();
    drive_a(1, 5'd7, 5'd7, 5'd7, 1, 1, 0, 2'b00);
    #1 check_eq("a_both_stall", 32'(ctl_a), 32'(C_STALL));
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("a_both_count", stall_a, 32'd2);

    // branch with simultaneous load-use: redirect wins
    next_cycle();
    drive_a(1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 2'b00);
    #1 check_eq("a_br_prio", 32'(ctl_a), 32'(C_RDET));
    next_cycle();
    drive_a(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("a_br_after", 32'(ctl_a), 32'(C_IDLE));
    check_eq("a_br_flush", flush_a, 32'd1);
    check_eq("a_br_stall", stall_a, 32'd2);

    // LOAD_STALL_CYCLES=3 with hazard held
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive_b(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 2'b00);
      #1 check_eq($sformatf("b_stall3_c%0d", i), 32'(ctl_b), 32'(C_STALL));
    end
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_stall3_run", 32'(ctl_b), 32'(C_IDLE));
    check_eq("b_stall3_count", 32'(stall_b), 32'd3);

    // REDIRECT_BUBBLES=3, jump one cycle, load-use in cycle 2 ignored
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b01);
    #1 check_eq("b_jmp_c1", 32'(ctl_b), 32'(C_RDET));
    next_cycle();
    drive_b(1, 5'd9, 5'd9, 5'd0, 1, 0, 0, 2'b00);
    #1 check_eq("b_jmp_c2", 32'(ctl_b), 32'(C_RHOLD));
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_jmp_c3", 32'(ctl_b), 32'(C_RHOLD));
    next_cycle();
    check_eq("b_jmp_c4", 32'(ctl_b), 32'(C_IDLE));
    check_eq("b_jmp_flush", 32'(flush_b), 32'd1);
    check_eq("b_jmp_stall", 32'(stall_b), 32'd3);

    // clear, then branch in the second stall cycle
    cnt_clr_b = 1'b1;
    next_cycle();
    cnt_clr_b = 1'b0;
    check_eq("b_clr_stall", 32'(stall_b), 32'd0);
    check_eq("b_clr_flush", 32'(flush_b), 32'd0);
    drive_b(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 2'b00);
    #1 check_eq("b_ab_c1", 32'(ctl_b), 32'(C_STALL));
    next_cycle();
    drive_b(1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 2'b00);
    #1 check_eq("b_ab_c2", 32'(ctl_b), 32'(C_RDET));
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_ab_c3", 32'(ctl_b), 32'(C_RHOLD));
    next_cycle();
    check_eq("b_ab_c4", 32'(ctl_b), 32'(C_RHOLD));
    next_cycle();
    check_eq("b_ab_c5", 32'(ctl_b), 32'(C_IDLE));
    check_eq("b_ab_stall", 32'(stall_b), 32'd1);
    check_eq("b_ab_flush", 32'(flush_b), 32'd1);

    // CNT_W=4 saturation over 20 bubble cycles, then clear together with an event
    cnt_clr_b = 1'b1;
    next_cycle();
    cnt_clr_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_b(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 2'b00);
      next_cycle();
    end
    check_eq("b_sat_stall", 32'(stall_b), 32'd15);
    cnt_clr_b = 1'b1;
    #1 check_eq("b_sat_ctl", 32'(ctl_b), 32'(C_STALL));
    next_cycle();
    cnt_clr_b = 1'b0;
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_clr_ev_stall", 32'(stall_b), 32'd0);
    check_eq("b_clr_ev_idle", 32'(ctl_b), 32'(C_IDLE));

    // clear together with a redirect
    next_cycle();
    cnt_clr_b = 1'b1;
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b10);
    #1 check_eq("b_clrj_c1", 32'(ctl_b), 32'(C_RDET));
    next_cycle();
    cnt_clr_b = 1'b0;
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_clrj_flush", 32'(flush_b), 32'd0);
    next_cycle();
    next_cycle();
    check_eq("b_clrj_idle", 32'(ctl_b), 32'(C_IDLE));

    // reset asserted mid-REDIR
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b01);
    #1 check_eq("b_rr_c1", 32'(ctl_b), 32'(C_RDET));
    next_cycle();
    drive_b(0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1 check_eq("b_rr_c2", 32'(ctl_b), 32'(C_RHOLD));
    check_eq("b_rr_flush", 32'(flush_b), 32'd1);
    rst_n = 1'b0;
    #1 check_eq("b_rr_rst_ctl", 32'(ctl_b), 32'(C_RST));
    check_eq("b_rr_rst_flush", 32'(flush_b), 32'd0);
    check_eq("b_rr_rst_stall", 32'(stall_b), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    #1 check_eq("b_rr_rel", 32'(ctl_b), 32'(C_IDLE));
    next_cycle();
    check_eq("b_rr_run", 32'(ctl_b), 32'(C_IDLE));
    check_eq("a_rr_run", 32'(ctl_a), 32'(C_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
